// File: rtl/pcm_mixer_pkg.sv
// Shared audio constants for the PCM/Sound Blaster mixer: default widths,
// SB idle timeout, mute code, SB midpoint and a saturating counter helper.
package pcm_mixer_pkg;

    localparam int PCM_W          = 24;
    localparam int SB_TIMEOUT_DEF = 4800;

    localparam logic [2:0] ATT_MUTE = 3'd7;
    localparam logic [7:0] SB_MID   = 8'd128;

    // Adds 0..2 events to a 16-bit counter, sticking at all-ones.
    function automatic logic [15:0] sat_add16(input logic [15:0] value, input logic [1:0] inc);
        logic [16:0] sum;
        sum = {1'b0, value} + 17'(inc);
        return sum[16] ? 16'hFFFF : sum[15:0];
    endfunction

endpackage

// File: rtl/pcm_mixer_sat_add.sv
// One mixer channel: attenuate the FIFO and SB terms (stage 2), then add
// them W+1 bits wide and clamp to the signed W-bit range (stage 3).
module pcm_sat_add
    import pcm_mixer_pkg::*;
#(
    parameter int W = PCM_W
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                load_scale,
    input  logic                load_sum,
    input  logic signed [W-1:0] fifo_term,
    input  logic signed [W-1:0] sb_term,
    input  logic        [2:0]   att_fifo,
    input  logic        [2:0]   att_sb,
    output logic signed [W-1:0] sample,
    output logic                clip
);

    logic signed [W-1:0] fifo_scaled;
    logic signed [W-1:0] sb_scaled;
    logic        [W:0]   sum;
    logic                over;
    logic                under;
    logic        [W-1:0] clamped;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fifo_scaled <= '0;
            sb_scaled   <= '0;
        end else if (load_scale) begin
            if (att_fifo == ATT_MUTE) fifo_scaled <= '0;
            else                      fifo_scaled <= fifo_term >>> att_fifo;
            if (att_sb == ATT_MUTE)   sb_scaled   <= '0;
            else                      sb_scaled   <= sb_term >>> att_sb;
        end
    end

    // Overflow shows up as the extra sign bit disagreeing with bit W-1.
    assign sum   = {fifo_scaled[W-1], fifo_scaled} + {sb_scaled[W-1], sb_scaled};
    assign over  = ~sum[W] &  sum[W-1];
    assign under =  sum[W] & ~sum[W-1];

    always_comb begin
        clamped = sum[W-1:0];
        if (over)       clamped = {1'b0, {(W-1){1'b1}}};
        else if (under) clamped = {1'b1, {(W-1){1'b0}}};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sample <= '0;
            clip   <= 1'b0;
        end else if (load_sum) begin
            sample <= clamped;
            clip   <= over | under;
        end else begin
            clip   <= 1'b0;
        end
    end

endmodule

// File: rtl/pcm_mixer.sv
// Mixes the audio FIFO stream with the 8-bit Sound Blaster DMA sample into
// a saturated stereo frame, three cycles after each encoder sample request.
module pcm_mixer
    import pcm_mixer_pkg::*;
#(
    parameter int SB_TIMEOUT = SB_TIMEOUT_DEF,
    parameter int W          = PCM_W
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                sample_req,
    input  logic signed [W-1:0] fifo_l,
    input  logic signed [W-1:0] fifo_r,
    input  logic        [7:0]   fifo_used,
    output logic                fifo_rdreq,
    input  logic        [7:0]   sb_pcm,
    input  logic                sb_strobe,
    input  logic        [2:0]   att_fifo,
    input  logic        [2:0]   att_sb,
    output logic signed [W-1:0] sample_l,
    output logic signed [W-1:0] sample_r,
    output logic                sample_valid,
    output logic        [15:0]  underrun_cnt,
    output logic        [15:0]  clip_cnt,
    output logic                sb_active
);

    localparam int IDLE_W = $clog2(SB_TIMEOUT + 1);

    logic                run;
    logic                accept;
    logic                fifo_has;
    logic [IDLE_W-1:0]   idle_cnt;
    logic [7:0]          sb_centered;
    logic signed [W-1:0] sb_term;
    logic                s1_valid;
    logic                s2_valid;
    logic                s3_valid;
    logic signed [W-1:0] s1_fifo_l;
    logic signed [W-1:0] s1_fifo_r;
    logic signed [W-1:0] s1_sb;
    logic                clip_l;
    logic                clip_r;

    // Requests are ignored until the first clock edge after reset release.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) run <= 1'b0;
        else        run <= 1'b1;
    end

    assign fifo_has   = fifo_used != 8'd0;
    assign accept     = sample_req & run;
    assign fifo_rdreq = accept & fifo_has;
    assign sb_active  = idle_cnt < IDLE_W'(SB_TIMEOUT);

    // Subtracting the midpoint mod 256 leaves the two's-complement byte,
    // which becomes the top bits of the W-bit term.
    assign sb_centered = sb_pcm - SB_MID;
    assign sb_term     = (sb_strobe | sb_active) ? {sb_centered, {(W-8){1'b0}}} : '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid  <= 1'b0;
            s2_valid  <= 1'b0;
            s3_valid  <= 1'b0;
            s1_fifo_l <= '0;
            s1_fifo_r <= '0;
            s1_sb     <= '0;
        end else begin
            s1_valid <= accept;
            s2_valid <= s1_valid;
            s3_valid <= s2_valid;
            if (accept) begin
                s1_fifo_l <= fifo_has ? fifo_l : '0;
                s1_fifo_r <= fifo_has ? fifo_r : '0;
                s1_sb     <= sb_term;
            end
        end
    end

    assign sample_valid = s3_valid;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idle_cnt <= IDLE_W'(SB_TIMEOUT);
        end else if (sb_strobe) begin
            idle_cnt <= '0;
        end else if (accept && sb_active) begin
            idle_cnt <= idle_cnt + IDLE_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            underrun_cnt <= '0;
            clip_cnt     <= '0;
        end else begin
            underrun_cnt <= sat_add16(underrun_cnt, {1'b0, accept & ~fifo_has});
            clip_cnt     <= sat_add16(clip_cnt, {1'b0, clip_l} + {1'b0, clip_r});
        end
    end

    pcm_sat_add #(.W(W)) u_left (
        .clk        (clk),
        .rst_n      (rst_n),
        .load_scale (s1_valid),
        .load_sum   (s2_valid),
        .fifo_term  (s1_fifo_l),
        .sb_term    (s1_sb),
        .att_fifo   (att_fifo),
        .att_sb     (att_sb),
        .sample     (sample_l),
        .clip       (clip_l)
    );

    pcm_sat_add #(.W(W)) u_right (
        .clk        (clk),
        .rst_n      (rst_n),
        .load_scale (s1_valid),
        .load_sum   (s2_valid),
        .fifo_term  (s1_fifo_r),
        .sb_term    (s1_sb),
        .att_fifo   (att_fifo),
        .att_sb     (att_sb),
        .sample     (sample_r),
        .clip       (clip_r)
    );

endmodule

// File: tb/tb_pcm_mixer.sv
// Self-checking bench for pcm_mixer: directed vector table, hand sequences for
// timeout and reset corners, and random traffic against a per-frame model.
module tb_pcm_mixer;

    localparam int     W    = 24;
    localparam int     T    = 4800;
    localparam longint MAXV = (64'sd1 <<< (W-1)) - 1;
    localparam longint MINV = -(64'sd1 <<< (W-1));

    logic                clk = 1'b0;
    logic                rst_n = 1'b0;
    logic                sample_req = 1'b0;
    logic                sb_strobe = 1'b0;
    logic signed [W-1:0] fifo_l = '0;
    logic signed [W-1:0] fifo_r = '0;
    logic        [7:0]   fifo_used = '0;
    logic        [7:0]   sb_pcm = 8'h80;
    logic        [2:0]   att_fifo = '0;
    logic        [2:0]   att_sb = '0;
    logic                fifo_rdreq;
    logic                sample_valid;
    logic                sb_active;
    logic signed [W-1:0] sample_l;
    logic signed [W-1:0] sample_r;
    logic        [15:0]  underrun_cnt;
    logic        [15:0]  clip_cnt;

    always #5 clk = ~clk;

    pcm_mixer #(.SB_TIMEOUT(T), .W(W)) dut (
        .clk(clk), .rst_n(rst_n), .sample_req(sample_req),
        .fifo_l(fifo_l), .fifo_r(fifo_r), .fifo_used(fifo_used), .fifo_rdreq(fifo_rdreq),
        .sb_pcm(sb_pcm), .sb_strobe(sb_strobe), .att_fifo(att_fifo), .att_sb(att_sb),
        .sample_l(sample_l), .sample_r(sample_r), .sample_valid(sample_valid),
        .underrun_cnt(underrun_cnt), .clip_cnt(clip_cnt), .sb_active(sb_active)
    );

    // What the bench remembers about each cycle's inputs.
    typedef struct {
        bit     acc;
        bit     has;
        longint l;
        longint r;
        int     sb;
        bit     sb_on;
        int     att_f;
        int     att_s;
    } snap_t;

    typedef struct {
        int     used;
        longint l;
        longint r;
        int     sb;
        bit     st;
        int     att_f;
        int     att_s;
        longint exp_l;
        longint exp_r;
    } vec_t;

    snap_t  ring [8];
    int     checks = 0;
    int     errors = 0;
    int     cyc = 0;
    int     m_idle = T;
    int     m_und = 0;
    int     m_clip = 0;
    bit     m_armed = 1'b0;
    longint m_l = 0;
    longint m_r = 0;
    int     cur_af = 0;
    int     cur_as = 0;

    task automatic check_val(input string name, input logic signed [63:0] act, input logic signed [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Floor division by 2^att, with 7 meaning silence.
    function automatic longint scale(input longint v, input int att);
        longint d;
        if (att == 7) return 0;
        d = longint'(1) << att;
        if (v >= 0) return v / d;
        return -((-v + d - 1) / d);
    endfunction

    function automatic longint mix(input longint a, input longint b, inout int nclip);
        longint s;
        s = a + b;
        if (s > MAXV) begin s = MAXV; nclip++; end
        if (s < MINV) begin s = MINV; nclip++; end
        return s;
    endfunction

    task automatic check_output();
        int     c;
        bit     exp_v;
        snap_t  f;
        snap_t  g;
        longint sbt;
        int     nclip;
        c     = cyc - 3;
        exp_v = (c >= 0) && ring[c & 7].acc;
        check_val("sample_valid", sample_valid, exp_v);
        check_val("clip_cnt", clip_cnt, m_clip);
        check_val("underrun_cnt", underrun_cnt, m_und);
        check_val("sb_active", sb_active, m_idle < T);
        if (exp_v) begin
            f     = ring[c & 7];
            g     = ring[(c + 1) & 7];
            nclip = 0;
            sbt   = f.sb_on ? longint'(f.sb - 128) * (longint'(1) << (W-8)) : 0;
            m_l   = mix(scale(f.has ? f.l : 0, g.att_f), scale(sbt, g.att_s), nclip);
            m_r   = mix(scale(f.has ? f.r : 0, g.att_f), scale(sbt, g.att_s), nclip);
            m_clip = (m_clip + nclip > 65535) ? 65535 : m_clip + nclip;
        end
        check_val("sample_l", sample_l, m_l);
        check_val("sample_r", sample_r, m_r);
    endtask

    task automatic apply_stimulus(input bit rv, input bit rq, input bit st, input int used,
                                  input longint l, input longint r, input int sb,
                                  input int af, input int as_);
        snap_t s;
        @(negedge clk);
        check_output();
        rst_n      = rv;
        sample_req = rq;
        sb_strobe  = st;
        fifo_used  = 8'(used);
        fifo_l     = W'(l);
        fifo_r     = W'(r);
        sb_pcm     = 8'(sb);
        att_fifo   = 3'(af);
        att_sb     = 3'(as_);
        #1;
        s.acc   = rv && m_armed && rq;
        s.has   = used != 0;
        s.l     = l;
        s.r     = r;
        s.sb    = sb;
        s.sb_on = st || (m_idle < T);
        s.att_f = af;
        s.att_s = as_;
        check_val("fifo_rdreq", fifo_rdreq, s.acc && s.has);
        ring[cyc & 7] = s;
        if (rv) begin
            if (st) m_idle = 0;
            else if (s.acc && m_idle < T) m_idle++;
            if (s.acc && !s.has && m_und < 65535) m_und++;
            m_armed = 1'b1;
        end else begin
            m_armed = 1'b0;
            m_idle  = T;
            m_und   = 0;
            m_clip  = 0;
            m_l     = 0;
            m_r     = 0;
            ring[(cyc - 1) & 7].acc = 1'b0;
            ring[(cyc - 2) & 7].acc = 1'b0;
        end
        cyc++;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) apply_stimulus(1'b1, 1'b0, 1'b0, 0, 0, 0, 128, cur_af, cur_as);
    endtask

    vec_t              vecs [6];
    logic signed [W-1:0] rl;
    logic signed [W-1:0] rr;

    initial begin
        vecs[0] = '{10, 'h100000, -'h100000, 128, 1'b0, 0, 0, 'h100000, -'h100000};
        vecs[1] = '{10, 'h7F0000, 0,         'hFF, 1'b1, 0, 0, 'h7FFFFF, 'h7F0000};
        vecs[2] = '{10, 0,        0,         'h00, 1'b1, 0, 1, -'h400000, -'h400000};
        vecs[3] = '{10, 'h123456, -1,        'h90, 1'b1, 7, 0, 'h100000, 'h100000};
        vecs[4] = '{10, -'h800000, -'h700000, 'h00, 1'b1, 0, 0, -'h800000, -'h800000};
        vecs[5] = '{10, 'h400001, -'h400001, 'h81, 1'b1, 2, 3, 'h102000, -'h0FE001};

        for (int i = 0; i < 3; i++) apply_stimulus(1'b0, 1'b0, 1'b0, 0, 0, 0, 128, 0, 0);
        idle(2);

        // Empty FIFO: three underruns, silent output while SB is idle.
        for (int i = 0; i < 3; i++) apply_stimulus(1'b1, 1'b1, 1'b0, 0, 'h55, 'h66, 128, 0, 0);
        idle(3);
        check_val("underrun_three", underrun_cnt, 3);
        check_val("underrun_out_l", sample_l, 0);
        check_val("underrun_out_r", sample_r, 0);

        foreach (vecs[k]) begin
            cur_af = vecs[k].att_f;
            cur_as = vecs[k].att_s;
            apply_stimulus(1'b1, 1'b1, vecs[k].st, vecs[k].used, vecs[k].l, vecs[k].r,
                           vecs[k].sb, vecs[k].att_f, vecs[k].att_s);
            idle(3);
            check_val($sformatf("vec%0d_l", k), sample_l, vecs[k].exp_l);
            check_val($sformatf("vec%0d_r", k), sample_r, vecs[k].exp_r);
        end
        idle(1);
        check_val("clip_total", clip_cnt, 3);

        for (int i = 0; i < 400; i++) begin
            rl = W'($urandom);
            rr = W'($urandom);
            apply_stimulus(1'b1, $urandom_range(0, 2) != 0, $urandom_range(0, 15) == 0,
                           ($urandom_range(0, 3) == 0) ? 0 : int'($urandom_range(1, 255)),
                           rl, rr, int'($urandom_range(0, 255)),
                           int'($urandom_range(0, 7)), int'($urandom_range(0, 7)));
        end
        cur_af = 0;
        cur_as = 0;
        idle(3);

        // SB timeout: active through the 4800th request, gone afterwards.
        apply_stimulus(1'b1, 1'b0, 1'b1, 0, 0, 0, 'hFF, 0, 0);
        for (int i = 0; i < T - 1; i++) apply_stimulus(1'b1, 1'b1, 1'b0, 5, 0, 0, 'hFF, 0, 0);
        idle(1);
        check_val("sb_active_before_last", sb_active, 1);
        apply_stimulus(1'b1, 1'b1, 1'b0, 5, 0, 0, 'hFF, 0, 0);
        idle(1);
        check_val("sb_active_after_last", sb_active, 0);
        idle(2);
        check_val("sb_last_frame_l", sample_l, 'h7F0000);
        apply_stimulus(1'b1, 1'b1, 1'b0, 5, 0, 0, 'hFF, 0, 0);
        idle(3);
        check_val("sb_timeout_no_dc", sample_l, 0);

        // Reset one cycle after a request discards the frame.
        apply_stimulus(1'b1, 1'b1, 1'b1, 5, 'h123456, 'h654321, 'hC0, 0, 0);
        for (int i = 0; i < 3; i++) apply_stimulus(1'b0, 1'b0, 1'b0, 5, 0, 0, 128, 0, 0);
        check_val("rst_sample_l", sample_l, 0);
        check_val("rst_sample_r", sample_r, 0);
        check_val("rst_sb_active", sb_active, 0);
        check_val("rst_clip_cnt", clip_cnt, 0);
        idle(5);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
